// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - CPU byte-bus responder: 128 KB RAM plus I/O page (RX/TX byte streams, cycle counter, stop)
module mem_io_responder #(
  parameter int          RAM_AW   = 17,
  parameter int          RX_DEPTH = 16,
  parameter int          TX_DEPTH = 16,
  parameter logic [31:0] CNT_INIT = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_full,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prog_stop
);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam int TXW = $clog2(TX_DEPTH);
  localparam logic [RXW:0] RX_ONE       = (RXW+1)'(1);
  localparam logic [TXW:0] TX_ONE       = (TXW+1)'(1);
  localparam logic [TXW:0] TX_NEAR_FULL = (TXW+1)'(TX_DEPTH - 1);

  logic [7:0] ram    [2**RAM_AW];
  logic [7:0] rx_mem [RX_DEPTH];
  logic [7:0] tx_mem [TX_DEPTH];

  logic [RXW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [TXW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [31:0]  cnt_q, snap_q, snap_d;
  logic [7:0]   mem_din_q, mem_din_d;
  logic         io_full_q, io_full_d;
  logic         stop_q, stop_d;
  logic         tx_ovf_q, tx_ovf_d;

  logic io_sel, io_data, io_cnt, io_stop, ram_we;
  logic rx_empty, rx_full, rx_push, rx_pop;
  logic tx_empty, tx_full, tx_req, tx_push, tx_pop;
  logic [7:0] tx_byte;
  logic unused_addr;

  assign unused_addr = ^mem_a[31:18];

  assign io_sel  = (mem_a[17:16] == 2'b11);
  assign io_data = io_sel && (mem_a[15:0] == 16'h0000);
  assign io_cnt  = io_sel && (mem_a[15:2] == 14'h0001);
  assign io_stop = io_sel && mem_wr && (mem_a[15:0] == 16'h0004);
  assign ram_we  = !io_sel && mem_wr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RXW] != rx_rd_q[RXW]) && (rx_wr_q[RXW-1:0] == rx_rd_q[RXW-1:0]);
  assign rx_push  = rx_valid && !rx_full;
  assign rx_pop   = io_data && !mem_wr && !rx_empty;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TXW] != tx_rd_q[TXW]) && (tx_wr_q[TXW-1:0] == tx_rd_q[TXW-1:0]);
  assign tx_req   = io_stop || (io_data && mem_wr && (mem_dout != 8'h00));
  assign tx_byte  = io_stop ? 8'h00 : mem_dout;
  assign tx_pop   = !tx_empty && tx_ready;
  // A same-cycle pop frees the slot, so a push into a full queue still lands.
  assign tx_push  = tx_req && (!tx_full || tx_pop);

  always_comb begin
    mem_din_d = 8'h00;
    snap_d    = snap_q;
    if (!io_sel) begin
      mem_din_d = ram[mem_a[RAM_AW-1:0]];
    end else if (!mem_wr) begin
      if (io_data) begin
        mem_din_d = rx_empty ? 8'h00 : rx_mem[rx_rd_q[RXW-1:0]];
      end else if (io_cnt) begin
        // Low byte comes from the live counter; the rest from the snapshot taken with it.
        case (mem_a[1:0])
          2'd0: begin
            mem_din_d = cnt_q[7:0];
            snap_d    = cnt_q;
          end
          2'd1:    mem_din_d = snap_q[15:8];
          2'd2:    mem_din_d = snap_q[23:16];
          default: mem_din_d = snap_q[31:24];
        endcase
      end
    end
    rx_wr_d   = rx_push ? rx_wr_q + RX_ONE : rx_wr_q;
    rx_rd_d   = rx_pop  ? rx_rd_q + RX_ONE : rx_rd_q;
    tx_wr_d   = tx_push ? tx_wr_q + TX_ONE : tx_wr_q;
    tx_rd_d   = tx_pop  ? tx_rd_q + TX_ONE : tx_rd_q;
    io_full_d = ((tx_wr_q - tx_rd_q) >= TX_NEAR_FULL);
    stop_d    = stop_q || io_stop;
    tx_ovf_d  = tx_ovf_q || (tx_req && !tx_push);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      cnt_q     <= CNT_INIT;
      snap_q    <= '0;
      mem_din_q <= 8'h00;
      io_full_q <= 1'b0;
      stop_q    <= 1'b0;
      tx_ovf_q  <= 1'b0;
    end else begin
      rx_wr_q   <= rx_wr_d;
      rx_rd_q   <= rx_rd_d;
      tx_wr_q   <= tx_wr_d;
      tx_rd_q   <= tx_rd_d;
      cnt_q     <= cnt_q + 32'd1;
      snap_q    <= snap_d;
      mem_din_q <= mem_din_d;
      io_full_q <= io_full_d;
      stop_q    <= stop_d;
      tx_ovf_q  <= tx_ovf_d;
    end
  end

  // Storage arrays are not reset; pointer reset discards their contents.
  always_ff @(posedge clk_in) begin
    if (ram_we)  ram[mem_a[RAM_AW-1:0]]    <= mem_dout;
    if (rx_push) rx_mem[rx_wr_q[RXW-1:0]] <= rx_data;
    if (tx_push) tx_mem[tx_wr_q[TXW-1:0]] <= tx_byte;
  end

  assign mem_din   = mem_din_q;
  assign io_full   = io_full_q;
  assign rx_ready  = !rx_full;
  assign tx_valid  = !tx_empty;
  assign tx_data   = tx_mem[tx_rd_q[TXW-1:0]];
  assign prog_stop = stop_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - directed, table-driven checks for mem_io_responder
module tb_mem_io_responder;
  localparam logic [31:0] CNT_INIT = 32'h1234_FFF0;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_full;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        prog_stop;

  mem_io_responder #(.RAM_AW(17), .RX_DEPTH(16), .TX_DEPTH(16), .CNT_INIT(CNT_INIT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .io_full(io_full), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .prog_stop(prog_stop)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
    mem_a    = a;
    mem_wr   = wr;
    mem_dout = d;
  endtask

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  dout;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic        chk_din;
    logic [7:0]  din;
    logic        rx_rdy;
    logic        tx_v;
    logic [7:0]  tx_d;
    logic        full;
  } vec_t;

  vec_t tbl [17];
  logic [7:0] tx_exp [16];

  initial begin
    //               addr         wr    dout   rxv   rxd    txr   chk   din    rxrdy txv   txd    full
    tbl[0]  = '{32'h0000_0123, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{32'h0000_0123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{32'h0002_0123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{32'h0000_0124, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{32'h0000_0124, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{32'h0000_0000, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{32'h0000_0000, 1'b0, 8'h00, 1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h42, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[9]  = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{32'h0003_0000, 1'b1, 8'h48, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h48, 1'b0};
    tbl[11] = '{32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h48, 1'b0};
    tbl[12] = '{32'h0003_0000, 1'b1, 8'h49, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h48, 1'b0};
    tbl[13] = '{32'h0003_0008, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h48, 1'b0};
    tbl[14] = '{32'h0003_0008, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h49, 1'b0};
    tbl[15] = '{32'h0003_FFFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[16] = '{32'h0003_0005, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};

    rst_in = 1'b1;
    drive(32'h0, 1'b0, 8'h00);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    cyc();
    cyc();
    rst_in = 1'b0;
    check("reset mem_din", mem_din, 8'h00);
    check("reset rx_ready", rx_ready, 1'b1);
    check("reset tx_valid", tx_valid, 1'b0);
    check("reset io_full", io_full, 1'b0);
    check("reset prog_stop", prog_stop, 1'b0);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].a, tbl[i].wr, tbl[i].dout);
      rx_valid = tbl[i].rxv;
      rx_data  = tbl[i].rxd;
      tx_ready = tbl[i].txr;
      cyc();
      if (tbl[i].chk_din) check($sformatf("vec%0d mem_din", i), mem_din, tbl[i].din);
      check($sformatf("vec%0d rx_ready", i), rx_ready, tbl[i].rx_rdy);
      check($sformatf("vec%0d tx_valid", i), tx_valid, tbl[i].tx_v);
      if (tbl[i].tx_v) check($sformatf("vec%0d tx_data", i), tx_data, tbl[i].tx_d);
      check($sformatf("vec%0d io_full", i), io_full, tbl[i].full);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b0;

    // RX push and pop in the same cycle while empty: read gets 0, byte stays queued
    drive(32'h0003_0000, 1'b0, 8'h00);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    cyc();
    check("rx push+pop empty", mem_din, 8'h00);
    rx_valid = 1'b0;
    cyc();
    check("rx after push+pop empty", mem_din, 8'h55);
    // same-cycle push and pop while non-empty
    drive(32'h0, 1'b0, 8'h00);
    rx_valid = 1'b1;
    rx_data  = 8'h60;
    cyc();
    drive(32'h0003_0000, 1'b0, 8'h00);
    rx_data = 8'h61;
    cyc();
    check("rx push+pop nonempty", mem_din, 8'h60);
    rx_valid = 1'b0;
    cyc();
    check("rx second", mem_din, 8'h61);
    cyc();
    check("rx drained", mem_din, 8'h00);

    // RX fill to full across the pointer wrap
    drive(32'h0, 1'b0, 8'h00);
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'h80 + 8'(i);
      cyc();
    end
    check("rx full ready", rx_ready, 1'b0);
    rx_data = 8'hFF;
    cyc();
    rx_valid = 1'b0;
    drive(32'h0003_0000, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      cyc();
      check($sformatf("rx full drain %0d", i), mem_din, 8'h80 + 8'(i));
    end
    cyc();
    check("rx dropped when full", mem_din, 8'h00);
    check("rx ready after drain", rx_ready, 1'b1);

    // TX fill, stall indication and overflow
    tx_ready = 1'b0;
    check("tx overflow clear", dut.tx_ovf_q, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      drive(32'h0003_0000, 1'b1, 8'(i));
      cyc();
      if (i == 15) check("io_full at 15", io_full, 1'b0);
      if (i == 16) check("io_full at 16", io_full, 1'b1);
    end
    drive(32'h0003_0000, 1'b1, 8'hEE);
    cyc();
    check("tx overflow set", dut.tx_ovf_q, 1'b1);
    check("tx head after overflow", tx_data, 8'h01);
    drive(32'h0003_0000, 1'b1, 8'hDD);
    tx_ready = 1'b1;
    cyc();
    check("tx full push+pop head", tx_data, 8'h02);
    drive(32'h0, 1'b0, 8'h00);
    for (int i = 0; i < 15; i++) tx_exp[i] = 8'(i + 2);
    tx_exp[15] = 8'hDD;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("tx drain valid %0d", i), tx_valid, 1'b1);
      check($sformatf("tx drain data %0d", i), tx_data, tx_exp[i]);
      cyc();
    end
    check("tx empty after drain", tx_valid, 1'b0);
    check("io_full after drain", io_full, 1'b0);
    tx_ready = 1'b0;

    // Program stop, then reset mid-operation
    drive(32'h0003_0004, 1'b1, 8'hAB);
    cyc();
    check("stop prog_stop", prog_stop, 1'b1);
    check("stop tx_valid", tx_valid, 1'b1);
    check("stop tx_data", tx_data, 8'h00);
    drive(32'h0, 1'b0, 8'h00);
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    cyc();
    check("stop sticky", prog_stop, 1'b1);
    rst_in = 1'b1;
    rx_data = 8'h33;
    drive(32'h0000_0123, 1'b0, 8'h00);
    cyc();
    rst_in   = 1'b0;
    rx_valid = 1'b0;
    check("rst prog_stop", prog_stop, 1'b0);
    check("rst tx_valid", tx_valid, 1'b0);
    check("rst in-flight mem_din", mem_din, 8'h00);
    check("rst rx_ready", rx_ready, 1'b1);
    check("rst io_full", io_full, 1'b0);

    // Counter is CNT_INIT here; present 0x30004 when it reads 0x1234FFFE
    drive(32'h0003_0000, 1'b0, 8'h00);
    cyc();
    check("rst rx discarded", mem_din, 8'h00);
    drive(32'h0, 1'b0, 8'h00);
    repeat (13) cyc();
    drive(32'h0003_0004, 1'b0, 8'h00);
    cyc();
    check("cnt byte0", mem_din, 8'hFE);
    drive(32'h0003_0005, 1'b0, 8'h00);
    cyc();
    check("cnt byte1", mem_din, 8'hFF);
    drive(32'h0003_0006, 1'b0, 8'h00);
    cyc();
    check("cnt byte2", mem_din, 8'h34);
    drive(32'h0003_0007, 1'b0, 8'h00);
    cyc();
    check("cnt byte3", mem_din, 8'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
